// File: rtl/ssem_alu_pkg.sv
// Shared definitions for the bit-serial ALU controller: FSM states and op-codes.
package ssem_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADD  = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] NEG  = 2'd2;
  localparam logic [1:0] PASS = 2'd3;

  // SUB and NEG add the ones-complement of B with a carry-in of 1
  function automatic logic op_inverts_b(input logic [1:0] op);
    return (op == SUB) || (op == NEG);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle for serial_alu_ctrl. io_overflow exists only when
// SERIAL_ALU_OVERFLOW_EN is defined.
interface serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             io_start;
  logic [1:0]       io_op;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_busy;
  logic             io_done;
  logic [WIDTH-1:0] io_result;
`ifdef SERIAL_ALU_OVERFLOW_EN
  logic             io_overflow;
`endif

  modport master (
    output io_start, io_op, io_a, io_b,
    input  io_busy, io_done, io_result
`ifdef SERIAL_ALU_OVERFLOW_EN
    , input io_overflow
`endif
  );

  modport slave (
    input  io_start, io_op, io_a, io_b,
    output io_busy, io_done, io_result
`ifdef SERIAL_ALU_OVERFLOW_EN
    , output io_overflow
`endif
  );
endinterface

// File: rtl/serial_alu_ctrl_fa.sv
// One-bit full adder used as the serial ALU bit slice.
module FullAdder (
  input  logic io_a,
  input  logic io_b,
  input  logic io_cin,
  output logic io_sum,
  output logic io_cout
);
  assign io_sum  = io_a ^ io_b ^ io_cin;
  assign io_cout = (io_a & io_b) | (io_cin & (io_a ^ io_b));
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ADD/SUB/NEG/PASS unit, one result bit per cycle, LSB first.
// Define SERIAL_ALU_OVERFLOW_EN to add the io_overflow output.
module serial_alu_ctrl
  import ssem_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  serial_alu_ctrl_if.slave io
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_next;
  logic             fa_a, fa_b, fa_sum, fa_cout;
`ifdef SERIAL_ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  FullAdder u_fa (
    .io_a   (fa_a),
    .io_b   (fa_b),
    .io_cin (carry_q),
    .io_sum (fa_sum),
    .io_cout(fa_cout)
  );

  always_comb begin
    fa_a     = a_q[0] & ((op_q == ADD) || (op_q == SUB));
    fa_b     = b_q[0] ^ op_inverts_b(op_q);
    sh_next  = {fa_sum, sh_q[WIDTH-1:1]};
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sh_d     = sh_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.io_start) begin
          a_d     = io.io_a;
          b_d     = io.io_b;
          op_d    = io.io_op;
          cnt_d   = '0;
          carry_d = op_inverts_b(io.io_op);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = sh_next;
        carry_d = (op_q == PASS) ? 1'b0 : fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // the visible result is only published on the final slice
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = sh_next;
          state_d  = DONE;
`ifdef SERIAL_ALU_OVERFLOW_EN
          ovf_d    = (op_q == PASS) ? 1'b0 : (carry_q ^ fa_cout);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sh_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ALU_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign io.io_busy   = (state_q == RUN);
  assign io.io_done   = (state_q == DONE);
  assign io.io_result = result_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
  assign io.io_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl (WIDTH=32 and WIDTH=8 instances).
module tb_serial_alu_ctrl;
  import ssem_alu_pkg::*;

  localparam int W  = 32;
  localparam int W8 = 8;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int          acc;
    int          dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t        q[$];
  exp_t        q8[$];
  int          m_free = 0;
  int          m8_free = 0;
  logic [64:0] r;
  logic [63:0] last_res = '0;
  logic [63:0] last_res8 = '0;
  logic        last_ovf = 1'b0;
  logic        last_ovf8 = 1'b0;
  logic        exp_done, exp_busy;

  serial_alu_ctrl_if #(.WIDTH(W))  bus32 ();
  serial_alu_ctrl_if #(.WIDTH(W8)) bus8 ();

  serial_alu_ctrl #(.WIDTH(W))  u_dut   (.clock(clk), .reset(rst), .io(bus32));
  serial_alu_ctrl #(.WIDTH(W8)) u_dut8  (.clock(clk), .reset(rst), .io(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {overflow, result} from plain modulo-2^w arithmetic
  function automatic logic [64:0] ref_model(input int w, input logic [1:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, s, a, b, res;
    logic        ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    s    = 64'd1 << (w - 1);
    a    = a_in & mask;
    b    = b_in & mask;
    ovf  = 1'b0;
    case (op)
      ADD: begin res = (a + b) & mask; ovf = (((a ^ res) & (b ^ res) & s) != 0); end
      SUB: begin res = (a - b) & mask; ovf = (((a ^ b) & (a ^ res) & s) != 0); end
      NEG: begin res = (64'd0 - b) & mask; ovf = (b == s); end
      default: res = b;
    endcase
    return {ovf, res};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Recorder: decides which starts the DUT must accept and queues the expectation
  always @(negedge clk) begin
    if (rst) begin
      m_free  = cyc + 1;
      m8_free = cyc + 1;
    end else begin
      if (bus32.io_start && cyc >= m_free) begin
        r = ref_model(W, bus32.io_op, 64'(bus32.io_a), 64'(bus32.io_b));
        q.push_back('{r[63:0], r[64], cyc, cyc + W + 1});
        m_free = cyc + W + 2;
      end
      if (bus8.io_start && cyc >= m8_free) begin
        r = ref_model(W8, bus8.io_op, 64'(bus8.io_a), 64'(bus8.io_b));
        q8.push_back('{r[63:0], r[64], cyc, cyc + W8 + 1});
        m8_free = cyc + W8 + 2;
      end
    end
  end

  // Monitor: every cycle compares handshake and held result against the scoreboard
  always @(negedge clk) begin
    exp_done = (q.size() > 0) && (q[0].dn == cyc);
    exp_busy = (q.size() > 0) && (cyc > q[0].acc) && (cyc < q[0].dn);
    chk("busy32", 64'(bus32.io_busy), 64'(exp_busy));
    chk("done32", 64'(bus32.io_done), 64'(exp_done));
    if (exp_done) begin
      chk("result32", 64'(bus32.io_result), q[0].res);
`ifdef SERIAL_ALU_OVERFLOW_EN
      chk("ovf32", 64'(bus32.io_overflow), 64'(q[0].ovf));
`endif
      last_res = q[0].res;
      last_ovf = q[0].ovf;
      void'(q.pop_front());
    end else begin
      chk("hold32", 64'(bus32.io_result), last_res);
`ifdef SERIAL_ALU_OVERFLOW_EN
      chk("ovfhold32", 64'(bus32.io_overflow), 64'(last_ovf));
`endif
    end

    exp_done = (q8.size() > 0) && (q8[0].dn == cyc);
    exp_busy = (q8.size() > 0) && (cyc > q8[0].acc) && (cyc < q8[0].dn);
    chk("busy8", 64'(bus8.io_busy), 64'(exp_busy));
    chk("done8", 64'(bus8.io_done), 64'(exp_done));
    if (exp_done) begin
      chk("result8", 64'(bus8.io_result), q8[0].res);
`ifdef SERIAL_ALU_OVERFLOW_EN
      chk("ovf8", 64'(bus8.io_overflow), 64'(q8[0].ovf));
`endif
      last_res8 = q8[0].res;
      last_ovf8 = q8[0].ovf;
      void'(q8.pop_front());
    end else begin
      chk("hold8", 64'(bus8.io_result), last_res8);
    end

    if (rst) begin
      q.delete();
      q8.delete();
      last_res  = '0;
      last_res8 = '0;
      last_ovf  = 1'b0;
      last_ovf8 = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.io_op    = op;
    bus32.io_a     = a;
    bus32.io_b     = b;
    bus32.io_start = 1'b1;
    tick(1);
    bus32.io_start = 1'b0;
    tick(W + 1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // start held during reset must not be accepted
    bus32.io_start = 1'b1;
    bus32.io_op    = ADD;
    bus32.io_a     = 32'h1;
    bus32.io_b     = 32'h1;
    bus8.io_start  = 1'b0;
    bus8.io_op     = ADD;
    bus8.io_a      = '0;
    bus8.io_b      = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    bus32.io_start = 1'b0;
    tick(2);

    issue(ADD,  32'h0000_0005, 32'h0000_0003);
    issue(SUB,  32'h0000_0003, 32'h0000_0005);
    issue(ADD,  32'h7FFF_FFFF, 32'h0000_0001);
    issue(NEG,  32'h0000_0000, 32'h0000_0001);
    issue(NEG,  32'h0000_0000, 32'h8000_0000);
    issue(PASS, 32'h1234_5678, 32'hDEAD_BEEF);

    // second start during RUN cycle 10 must be ignored
    bus32.io_op = ADD; bus32.io_a = 32'h0000_1234; bus32.io_b = 32'h0000_1111;
    bus32.io_start = 1'b1;
    tick(1);
    bus32.io_start = 1'b0;
    tick(9);
    bus32.io_op = SUB; bus32.io_a = 32'hAAAA_0000; bus32.io_b = 32'h0000_5555;
    bus32.io_start = 1'b1;
    tick(1);
    bus32.io_start = 1'b0;
    tick(W - 9);

    // reset during RUN cycle 16 aborts without a done pulse
    bus32.io_op = SUB; bus32.io_a = 32'h0F0F_0F0F; bus32.io_b = 32'h1234_0000;
    bus32.io_start = 1'b1;
    tick(1);
    bus32.io_start = 1'b0;
    tick(15);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    issue(ADD, 32'h1, 32'h1);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
      tick($urandom_range(0, 2));
    end

    // start held high: one accept every W+2 cycles
    bus32.io_start = 1'b1;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      bus32.io_op = 2'($urandom_range(0, 3));
      bus32.io_a  = pick_operand();
      bus32.io_b  = pick_operand();
      tick(1);
    end
    bus32.io_start = 1'b0;
    tick(W + 3);

    bus8.io_op = ADD; bus8.io_a = 8'hFF; bus8.io_b = 8'h01;
    bus8.io_start = 1'b1;
    tick(3 * (W8 + 2));
    bus8.io_start = 1'b0;
    tick(W8 + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
